// File: rtl/mult_hilo_unit.sv
// Iterative unsigned shift-add multiplier owning the HI/LO registers.
// Handles MULT (WORD_LEN-cycle run with pipeline stall) and the MFHI/MFLO reads.
module mult_hilo_unit #(
    parameter int unsigned WORD_LEN = 16,
    parameter int unsigned EXE_CMD_LEN = 4,
    parameter logic [EXE_CMD_LEN-1:0] CMD_MULT = 4'd10,
    parameter logic [EXE_CMD_LEN-1:0] CMD_MFHI = 4'd11,
    parameter logic [EXE_CMD_LEN-1:0] CMD_MFLO = 4'd12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LEN-1:0]    val1,
    input  logic [WORD_LEN-1:0]    val2,
    input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
    input  logic                   valid_in,
    input  logic                   flush,
    output logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LEN-1:0]    result,
    output logic [WORD_LEN-1:0]    hi_out,
    output logic [WORD_LEN-1:0]    lo_out
);

    localparam int unsigned CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WORD_LEN - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                  state_q;
    logic [WORD_LEN-1:0]     hi_q;
    logic [WORD_LEN-1:0]     lo_q;
    logic [2*WORD_LEN-1:0]   acc_q;
    logic [2*WORD_LEN-1:0]   mcand_q;
    logic [WORD_LEN-1:0]     mplier_q;
    logic [CW-1:0]           count_q;
    logic                    done_q;

    logic                    start;
    logic                    last_iter;
    logic [2*WORD_LEN-1:0]   acc_next;

    always_comb begin
        start     = valid_in && (EXE_CMD == CMD_MULT) && (state_q == StIdle);
        last_iter = (state_q == StRun) && (count_q == LastCount);
        // Partial product of the current iteration, so the final commit includes it.
        acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        stall     = start || ((state_q == StRun) && !last_iter);
        busy      = (state_q == StRun);
        done      = done_q;
        hi_out    = hi_q;
        lo_out    = lo_q;
        result    = '0;
        if (valid_in && (EXE_CMD == CMD_MFHI)) begin
            result = hi_q;
        end else if (valid_in && (EXE_CMD == CMD_MFLO)) begin
            result = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else if (flush) begin
            // Abort discards any in-flight product, even on its final iteration.
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= {{WORD_LEN{1'b0}}, val1};
                        mplier_q <= val2;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (last_iter) begin
                        hi_q    <= acc_next[2*WORD_LEN-1:WORD_LEN];
                        lo_q    <= acc_next[WORD_LEN-1:0];
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
